// File: rtl/vrf_pkg.sv
// Shared definitions for the vector register file: default geometry, clear-engine
// state encoding and the lane merge used for masked writes and write bypass.
package vrf_pkg;

    localparam int VRF_LANES  = 3;
    localparam int VRF_LANE_W = 16;
    localparam int VRF_DEPTH  = 32;
    // Upper bound on word width accepted by lane_merge; callers cast in and out.
    localparam int VRF_MAX_W  = 1024;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } vrf_state_e;

    // bmask is the lane mask expanded to one bit per data bit.
    function automatic logic [VRF_MAX_W-1:0] lane_merge(
        input logic [VRF_MAX_W-1:0] old_v,
        input logic [VRF_MAX_W-1:0] new_v,
        input logic [VRF_MAX_W-1:0] bmask
    );
        return (old_v & ~bmask) | (new_v & bmask);
    endfunction

endpackage

// File: rtl/vector_register_file_clear_seq.sv
// Bulk-clear sequencer: walks a pointer over every entry once, one entry per cycle,
// and holds busy high for exactly DEPTH cycles.
module vrf_clear_seq
    import vrf_pkg::*;
#(
    parameter  int DEPTH = VRF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr
);

    vrf_state_e    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign busy     = (state_q == ST_CLEAR);
    assign clr_en   = busy;
    assign clr_addr = ptr_q;

endmodule

// File: rtl/vector_register_file.sv
// Vector register file: two registered read ports, one lane-masked write port with
// same-cycle bypass, optional hardwired zero entry and a sequenced bulk clear.
module vector_register_file
    import vrf_pkg::*;
#(
    parameter  int LANES    = VRF_LANES,
    parameter  int LANE_W   = VRF_LANE_W,
    parameter  int DEPTH    = VRF_DEPTH,
    parameter  bit ZERO_REG = 1'b0,
    localparam int AW       = $clog2(DEPTH),
    localparam int W        = LANES * LANE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_RF,
    input  logic [LANES-1:0] wmask,
    input  logic [AW-1:0]    A1,
    input  logic [AW-1:0]    A2,
    input  logic [AW-1:0]    A3,
    input  logic [W-1:0]     WD3,
    input  logic             clr_req,
    output logic [W-1:0]     RD1,
    output logic [W-1:0]     RD2,
    output logic             busy
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [W-1:0]  rd1_q, rd1_d, rd2_q, rd2_d;
    logic [W-1:0]  bmask, wr_merged;
    logic          wr_ok, clr_en;
    logic [AW-1:0] clr_addr;

    vrf_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    for (genvar i = 0; i < LANES; i++) begin : g_bmask
        assign bmask[i*LANE_W +: LANE_W] = {LANE_W{wmask[i]}};
    end

    // Writes are dropped while the clear engine owns the array.
    assign wr_ok     = we_RF && !clr_en && !(ZERO_REG && (A3 == '0));
    assign wr_merged = W'(lane_merge(VRF_MAX_W'(mem_q[A3]), VRF_MAX_W'(WD3),
                                     VRF_MAX_W'(bmask)));

    always_comb begin
        mem_d = mem_q;
        if (clr_en) begin
            mem_d[clr_addr] = '0;
        end else if (wr_ok) begin
            mem_d[A3] = wr_merged;
        end
    end

    // Read ports capture the post-update contents of the addressed entry.
    always_comb begin
        rd1_d = mem_q[A1];
        rd2_d = mem_q[A2];
        if (clr_en && (A1 == clr_addr)) rd1_d = '0;
        else if (wr_ok && (A1 == A3))   rd1_d = wr_merged;
        if (clr_en && (A2 == clr_addr)) rd2_d = '0;
        else if (wr_ok && (A2 == A3))   rd2_d = wr_merged;
        if (ZERO_REG && (A1 == '0))     rd1_d = '0;
        if (ZERO_REG && (A2 == '0))     rd2_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd1_q <= '0;
            rd2_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
        end
    end

    assign RD1 = rd1_q;
    assign RD2 = rd2_q;

endmodule

// File: tb/tb_vector_register_file.sv
// Randomized bench for vector_register_file: a default instance and a ZERO_REG
// instance share stimulus and are compared against an array-level model each cycle.
module tb_vector_register_file;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we_RF = 1'b0;
    logic [2:0]  wmask = '0;
    logic [4:0]  A1 = '0, A2 = '0, A3 = '0;
    logic [47:0] WD3 = '0;
    logic        clr_req = 1'b0;
    logic [47:0] rd1, rd2, rd1_z, rd2_z;
    logic        busy, busy_z;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: array contents and clear progress.
    logic [47:0] m0 [32];
    logic [47:0] mz [32];
    int          m_busy = 0;
    int          m_ptr  = 0;

    always #5 clk = ~clk;

    vector_register_file dut (
        .clk(clk), .rst(rst), .we_RF(we_RF), .wmask(wmask), .A1(A1), .A2(A2), .A3(A3),
        .WD3(WD3), .clr_req(clr_req), .RD1(rd1), .RD2(rd2), .busy(busy)
    );

    vector_register_file #(.ZERO_REG(1'b1)) dut_z (
        .clk(clk), .rst(rst), .we_RF(we_RF), .wmask(wmask), .A1(A1), .A2(A2), .A3(A3),
        .WD3(WD3), .clr_req(clr_req), .RD1(rd1_z), .RD2(rd2_z), .busy(busy_z)
    );

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m0[i] = '0;
            mz[i] = '0;
        end
        m_busy = 0;
        m_ptr  = 0;
    endtask

    task automatic model_step(input logic we, input logic [2:0] m, input logic [4:0] a3,
                              input logic [47:0] wd, input logic clr);
        if (m_busy != 0) begin
            m0[m_ptr] = '0;
            mz[m_ptr] = '0;
            m_ptr++;
            if (m_ptr == 32) begin
                m_busy = 0;
                m_ptr  = 0;
            end
        end else begin
            if (we) begin
                for (int l = 0; l < 3; l++) begin
                    if (m[l]) begin
                        m0[a3][l*16 +: 16] = wd[l*16 +: 16];
                        if (a3 != 5'd0) mz[a3][l*16 +: 16] = wd[l*16 +: 16];
                    end
                end
            end
            if (clr) begin
                m_busy = 1;
                m_ptr  = 0;
            end
        end
    endtask

    // One clock: drive, let the edge happen, advance the model, compare everything.
    task automatic cyc(input logic we, input logic [2:0] m, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] a3, input logic [47:0] wd,
                       input logic clr);
        we_RF = we; wmask = m; A1 = a1; A2 = a2; A3 = a3; WD3 = wd; clr_req = clr;
        @(posedge clk);
        model_step(we, m, a3, wd, clr);
        #1;
        check("rd1",    rd1,   m0[a1]);
        check("rd2",    rd2,   m0[a2]);
        check("rd1_z",  rd1_z, mz[a1]);
        check("rd2_z",  rd2_z, mz[a2]);
        check("busy",   {47'd0, busy},   48'(m_busy));
        check("busy_z", {47'd0, busy_z}, 48'(m_busy));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_rd1",  rd1,   48'd0);
        check("rst_rd2",  rd2,   48'd0);
        check("rst_rd1z", rd1_z, 48'd0);
        check("rst_busy", {47'd0, busy},   48'd0);
        check("rst_bz",   {47'd0, busy_z}, 48'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic fill_all();
        for (int i = 0; i < 32; i++)
            cyc(1'b1, 3'b111, 5'(i), 5'(31 - i), 5'(i), 48'({$urandom(), $urandom()}) | 48'd1, 1'b0);
    endtask

    task automatic read_all();
        for (int i = 0; i < 32; i++) cyc(1'b0, 3'b000, 5'(i), 5'(31 - i), 5'd0, 48'd0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        model_reset();
        we_RF = 1'b1; wmask = 3'b101; A1 = 5'd9; A2 = 5'd4; A3 = 5'd9; WD3 = 48'hDEAD_BEEF_CAFE; clr_req = 1'b1;
        #1;
        do_reset();
        read_all();

        // masked write then readback
        cyc(1'b1, 3'b111, 5'd1, 5'd2, 5'd5, 48'hAAAA_BBBB_CCCC, 1'b0);
        cyc(1'b1, 3'b010, 5'd1, 5'd2, 5'd5, 48'h1111_2222_3333, 1'b0);
        cyc(1'b0, 3'b000, 5'd5, 5'd5, 5'd0, 48'd0, 1'b0);
        check("masked_rd1", rd1, 48'hAAAA_2222_CCCC);
        cyc(1'b1, 3'b000, 5'd5, 5'd5, 5'd5, 48'hFFFF_FFFF_FFFF, 1'b0);
        check("mask0_noop", rd2, 48'hAAAA_2222_CCCC);

        // same-cycle bypass on both ports
        cyc(1'b1, 3'b111, 5'd7, 5'd7, 5'd7, 48'h0123_4567_89AB, 1'b0);
        check("byp_rd1", rd1, 48'h0123_4567_89AB);
        check("byp_rd2", rd2, 48'h0123_4567_89AB);

        // zero register: write to 0 ignored on the ZERO_REG instance, even on bypass
        cyc(1'b1, 3'b111, 5'd0, 5'd0, 5'd0, 48'hFFFF_FFFF_FFFF, 1'b0);
        check("zero_byp_z", rd1_z, 48'd0);
        check("zero_byp",   rd1,   48'hFFFF_FFFF_FFFF);
        cyc(1'b0, 3'b000, 5'd0, 5'd7, 5'd0, 48'd0, 1'b0);
        check("zero_rd_z", rd1_z, 48'd0);

        // full clear with a dropped write to entry 3
        fill_all();
        cyc(1'b0, 3'b000, 5'd0, 5'd1, 5'd0, 48'd0, 1'b1);
        cnt = busy ? 1 : 0;
        for (int k = 0; k < 40; k++) begin
            if (k == 8) cyc(1'b1, 3'b111, 5'd3, 5'd3, 5'd3, 48'h5555_6666_7777, 1'b1);
            else        cyc(1'b0, 3'b000, 5'(k + 1), 5'(k + 2), 5'd0, 48'd0, 1'b0);
            if (busy) cnt++;
        end
        check("clr_len", 48'(cnt), 48'd32);
        read_all();
        cyc(1'b0, 3'b000, 5'd3, 5'd31, 5'd0, 48'd0, 1'b0);
        check("clr_drop3", rd1, 48'd0);

        // reset in the middle of a clear, then a fresh clear from pointer 0
        fill_all();
        cyc(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 48'd0, 1'b1);
        for (int k = 0; k < 9; k++) cyc(1'b0, 3'b000, 5'(k), 5'(k + 1), 5'd0, 48'd0, 1'b0);
        #2;
        do_reset();
        read_all();
        fill_all();
        cyc(1'b0, 3'b000, 5'd0, 5'd1, 5'd0, 48'd0, 1'b1);
        for (int k = 0; k < 40 && m_busy != 0; k++)
            cyc(1'b0, 3'b000, 5'(k), 5'(k + 1), 5'd0, 48'd0, 1'b0);
        check("clr2_done", {47'd0, busy}, 48'd0);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic [4:0] a1, a2, a3;
            a3 = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 1) != 0) ? a3 : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 2) == 0) ? a3 : 5'($urandom_range(0, 31));
            cyc($urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)), a1, a2, a3,
                48'({$urandom(), $urandom()}), $urandom_range(0, 99) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/vector_register_file.md
# vector_register_file

Parametrised vector register file for the vector datapath; successor to the fixed 32 × 48-bit vector bank. Provides two registered read ports and one write port with per-lane write mask, same-cycle write-to-read bypass, an optional hardwired zero register, and a sequenced bulk-clear engine. Sits between decode (register addresses) and the vector ALU / writeback stage.

## Interface
- LANES, 3, lanes per vector word
- LANE_W, 16, bits per lane; word width W = LANES*LANE_W (default 48)
- DEPTH, 32, number of vector registers (power of two, ≥ 2)
- AW, $clog2(DEPTH), address width (derived, not overridden)
- ZERO_REG, 0, 1 = entry 0 always reads zero and ignores writes

- clk  in  1  single clock; all state changes on posedge
- rst  in  1  asynchronous, active-low reset
- we_RF  in  1  write enable
- wmask  in  LANES  per-lane write enable; lane i written only if wmask[i]
- A1, A2  in  AW  read addresses
- A3  in  AW  write address
- WD3  in  W  write data; lane i = WD3[i*LANE_W +: LANE_W]
- clr_req  in  1  start bulk clear (sampled in IDLE only)
- RD1, RD2  out  W  registered read data
- busy  out  1  high while clear engine runs

## Operation
- Reset (rst low, async): all DEPTH entries = 0, RD1 = RD2 = 0, busy = 0, state IDLE, clear pointer = 0.
- Write (IDLE, we_RF=1): on posedge, for each i with wmask[i]=1, entry[A3] lane i ← WD3 lane i; unmasked lanes keep old value. wmask = 0 is a no-op.
- ZERO_REG=1: writes to A3=0 discarded; reads of address 0 return 0.
- Read: on every posedge, RDn ← entry[An] (both ports independent; A1 = A2 allowed).
- Bypass: if we_RF=1, state IDLE, and An = A3 (and not suppressed by ZERO_REG), RDn ← lane-merged value (masked lanes from WD3, others from entry[A3]), i.e. the post-write contents.
- Clear FSM:
  - IDLE: clr_req=1 → CLEAR, pointer ← 0, busy ← 1. A write present in the same cycle as clr_req is performed; bypass applies.
  - CLEAR: each cycle entry[pointer] ← 0, pointer ← pointer+1; when pointer = DEPTH-1 → IDLE, busy ← 0, pointer ← 0.
  - In CLEAR: we_RF ignored (write dropped, no bypass); clr_req ignored; reads continue and return current array contents; a read of the entry being cleared this cycle returns 0 (clear bypass).
- Reset asserted mid-clear: immediate return to reset state; no partial sweep resumes.

## Timing
- Read latency: 1 cycle (address at edge k → data valid after edge k+1 … i.e., registered at edge following address setup).
- Write visible to a read at the same edge via bypass; to a read at any later edge via array.
- Clear duration: exactly DEPTH cycles with busy=1; busy rises on the edge sampling clr_req, falls on the edge that clears entry DEPTH-1.
- First accepted write after clear: the cycle busy is observed low.

## Structure
- Shared package vrf_pkg: state enum (IDLE, CLEAR), default LANES/LANE_W/DEPTH constants, lane_merge function (old, new, mask).
- One sub-module natural: vrf_clear_seq (FSM + pointer, outputs busy, clr_en, clr_addr); storage, write merge and read/bypass logic stay in the top.

## Test plan
- Reset: drive arbitrary inputs, rst low → RD1=RD2=0, busy=0; read all 32 entries after release → all 0.
- Masked write: write A3=5, WD3=48'hAAAA_BBBB_CCCC, wmask=3'b111; then A3=5, WD3=48'h1111_2222_3333, wmask=3'b010 → read 5 returns 48'hAAAA_2222_CCCC.
- Bypass: same cycle we_RF=1, A3=A1=A2=7, WD3=48'h0123_4567_89AB, mask=111 → RD1=RD2=48'h0123_4567_89AB one cycle later.
- ZERO_REG=1: write 48'hFFFF_FFFF_FFFF to 0 → read 0 returns 0, including bypass cycle.
- Clear: fill all entries with nonzero, pulse clr_req → busy high exactly 32 cycles; write to 3 during CLEAR dropped; afterwards all entries read 0.
- Reset mid-clear: assert rst at clear cycle 10 → busy=0 immediately; after release entries all 0, new clr_req restarts at pointer 0.
